// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller:
// forwarding encodings, controller state enum and the x0 register index.
package pipe_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        RUN,
        MEM_WAIT
    } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard bundle between the pipeline datapath and the hazard controller.
// master: datapath side (drives register ids/events, takes controls).
// slave:  controller side (takes ids/events, drives stall/flush/forward).
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    import pipe_pkg::*;

    logic [4:0]       Rs1D;
    logic [4:0]       Rs2D;
    logic [4:0]       Rs1E;
    logic [4:0]       Rs2E;
    logic [4:0]       RdE;
    logic [4:0]       RdM;
    logic [4:0]       RdW;
    logic             RegWriteM;
    logic             RegWriteW;
    logic             LoadE;
    logic             PCSrcE;
    logic             MemReqM;
    logic             MemReadyM;

    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             StallM;
    logic             FlushD;
    logic             FlushE;
    logic             BubbleW;
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic             MemErr;
    logic [CNT_W-1:0] StallCount;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, LoadE, PCSrcE,
        output MemReqM, MemReadyM,
        input  StallF, StallD, StallE, StallM,
        input  FlushD, FlushE, BubbleW,
        input  ForwardAE, ForwardBE, MemErr, StallCount
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, LoadE, PCSrcE,
        input  MemReqM, MemReadyM,
        output StallF, StallD, StallE, StallM,
        output FlushD, FlushE, BubbleW,
        output ForwardAE, ForwardBE, MemErr, StallCount
    );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd.sv
// Forwarding select for one EX operand: M beats W, x0 never forwards.
// Ports: Rs_i operand reg, RdM_i/RdW_i + write enables, Fwd_o select.
module fwd_unit
    import pipe_pkg::*;
(
    input  logic [4:0] Rs_i,
    input  logic [4:0] RdM_i,
    input  logic [4:0] RdW_i,
    input  logic       RegWriteM_i,
    input  logic       RegWriteW_i,
    output logic [1:0] Fwd_o
);

    logic hit_m;
    logic hit_w;

    assign hit_m = RegWriteM_i && (RdM_i != REG_ZERO) && (RdM_i == Rs_i);
    assign hit_w = RegWriteW_i && (RdW_i != REG_ZERO) && (RdW_i == Rs_i);

    always_comb begin
        Fwd_o = FWD_RF;
        if (hit_m) begin
            Fwd_o = FWD_M;
        end else if (hit_w) begin
            Fwd_o = FWD_W;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use/branch/memory-wait stalls and
// flushes, EX forwarding, memory timeout watchdog, stall-cycle counter.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    pipe_hazard_ctrl_if.slave    hz
);

    localparam int TW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMR_LAST = TW'(MEM_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic frozen;
    logic load_use;

    // The whole MEM_WAIT state stalls, including the cycle memory
    // answers, so E/M only advances on the following edge.
    assign frozen = (state_q == MEM_WAIT)
                 || (hz.MemReqM && !hz.MemReadyM);

    assign load_use = hz.LoadE && (hz.RdE != REG_ZERO)
                   && ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q <= RUN;
            tmr_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        err_d   = err_q;
        unique case (state_q)
            RUN: begin
                if (hz.MemReqM && !hz.MemReadyM) begin
                    state_d = MEM_WAIT;
                    tmr_d   = '0;
                end
            end
            MEM_WAIT: begin
                if (hz.MemReadyM) begin
                    state_d = RUN;
                end else if (tmr_q == TMR_LAST) begin
                    // Watchdog: give up on the access and flag it.
                    err_d   = 1'b1;
                    state_d = RUN;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
        endcase
    end

    // Reset gates the controls so nothing stalls in the reset cycle.
    always_comb begin
        hz.StallF  = 1'b0;
        hz.StallD  = 1'b0;
        hz.StallE  = 1'b0;
        hz.StallM  = 1'b0;
        hz.FlushD  = 1'b0;
        hz.FlushE  = 1'b0;
        hz.BubbleW = 1'b0;
        if (Rst_n) begin
            if (frozen) begin
                hz.StallF  = 1'b1;
                hz.StallD  = 1'b1;
                hz.StallE  = 1'b1;
                hz.StallM  = 1'b1;
                hz.BubbleW = 1'b1;
            end else if (hz.PCSrcE) begin
                hz.FlushD = 1'b1;
                hz.FlushE = 1'b1;
            end else if (load_use) begin
                hz.StallF = 1'b1;
                hz.StallD = 1'b1;
                hz.FlushE = 1'b1;
            end
        end
    end

    assign cnt_d = hz.StallF ? cnt_q + CNT_W'(1) : cnt_q;

    assign hz.MemErr     = err_q;
    assign hz.StallCount = cnt_q;

    fwd_unit u_fwd_a (
        .Rs_i        (hz.Rs1E),
        .RdM_i       (hz.RdM),
        .RdW_i       (hz.RdW),
        .RegWriteM_i (hz.RegWriteM),
        .RegWriteW_i (hz.RegWriteW),
        .Fwd_o       (hz.ForwardAE)
    );

    fwd_unit u_fwd_b (
        .Rs_i        (hz.Rs2E),
        .RdM_i       (hz.RdM),
        .RdW_i       (hz.RdW),
        .RegWriteM_i (hz.RegWriteM),
        .RegWriteW_i (hz.RegWriteW),
        .Fwd_o       (hz.ForwardBE)
    );

endmodule
